player_life_ctrl: RTL and testbench

Sequences the player ship's life cycle for the STG core: normal play, hit, respawn, post-respawn invulnerability and game over. It consumes the collision flag from the hit detector and drives the player module's movement enable, hit-sprite select, visibility, respawn and life count. It also owns the movement tick divider, so the player datapath moves only when this controller allows it.

---
 rtl/stg_pkg.sv | 29 ++
 rtl/tick_gen.sv | 40 ++++
 rtl/player_life_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_player_life_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stg_pkg.sv
// -----------------------------------------------------------------------------
// stg_pkg
// Shared types and constants for the STG core player logic.
//   life_state_t   : player life-cycle FSM state encoding
//   PLAYER_START_* : player reload position used on respawn
//   LIVES_W        : width of the remaining-lives count
//   clog2_min1     : $clog2 clamped to at least one bit for counter widths
// -----------------------------------------------------------------------------
package stg_pkg;

    localparam int PLAYER_START_X = 192;
    localparam int PLAYER_START_Y = 400;
    localparam int LIVES_W        = 3;

    typedef enum logic [2:0] {
        ST_ALIVE     = 3'd0,
        ST_HIT       = 3'd1,
        ST_RESPAWN   = 3'd2,
        ST_INVULN    = 3'd3,
        ST_GAME_OVER = 3'd4
    } life_state_t;

    // Counter width for a range of v values; never returns 0 so a degenerate
    // parameter still yields a legal vector.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running divider: counts 0..DIV-1 and wraps, raising tick_o for the one
// cycle in which the count equals DIV-1 (period of exactly DIV clk cycles).
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset (count returns to 0)
//   tick_o  one-cycle tick
// -----------------------------------------------------------------------------
module tick_gen
    import stg_pkg::*;
#(
    parameter int unsigned DIV = 2000000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned      CNT_W    = clog2_min1(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/player_life_ctrl.sv
// -----------------------------------------------------------------------------
// player_life_ctrl
// Player ship life-cycle sequencer: normal play, hit, respawn, post-respawn
// invulnerability and game over. Owns the movement tick divider.
//
// Ports:
//   clk_i            system clock
//   reset_i          asynchronous active-high reset
//   collision_i      player overlaps a hazard this cycle (level)
//   restart_i        restart request, honoured only in GAME_OVER (level)
//   move_en_o        one-cycle pulse: player may step one pixel
//   respawn_o        one-cycle pulse: player reloads its start position
//   hit_sel_o        selects the hit sprite
//   sprite_visible_o gates player_on
//   invuln_o         collisions are being ignored
//   lives_o          remaining lives
//   game_over_o      high in GAME_OVER
//
// Build option: define PLAYER_BLINK_EN to blink the sprite during INVULN,
// toggling every BLINK_TICKS ticks. Without it the blink counter is absent.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ALIVE      | normal play, a collision costs a life
// HIT        | hit sprite shown, movement frozen for HIT_TICKS ticks
// RESPAWN    | single cycle, player reloads start position
// INVULN     | INVULN_TICKS ticks of play with collisions ignored
// GAME_OVER  | no lives left, waiting for restart
// -----------------------------------------------------------------------------
module player_life_ctrl
    import stg_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 2000000,
    parameter int unsigned HIT_TICKS    = 30,
    parameter int unsigned INVULN_TICKS = 120,
    parameter int unsigned BLINK_TICKS  = 8,
    parameter int unsigned LIVES_INIT   = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               collision_i,
    input  logic               restart_i,
    output logic               move_en_o,
    output logic               respawn_o,
    output logic               hit_sel_o,
    output logic               sprite_visible_o,
    output logic               invuln_o,
    output logic [LIVES_W-1:0] lives_o,
    output logic               game_over_o
);

    if (LIVES_INIT < 1 || LIVES_INIT > 7 || HIT_TICKS < 1 || INVULN_TICKS < 1
        || BLINK_TICKS < 1) begin : g_bad_params
        $error("player_life_ctrl: illegal parameter value");
    end

    localparam int unsigned TMR_MAX = (HIT_TICKS > INVULN_TICKS) ? HIT_TICKS : INVULN_TICKS;
    localparam int unsigned TMR_W   = clog2_min1(TMR_MAX);

    localparam logic [TMR_W-1:0]   HIT_LAST  = TMR_W'(HIT_TICKS - 1);
    localparam logic [TMR_W-1:0]   INV_LAST  = TMR_W'(INVULN_TICKS - 1);
    localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);

    logic tick;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (reset_i),
        .tick_o (tick)
    );

    life_state_t        state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [LIVES_W-1:0] lives_q, lives_d;

    logic move_en_q, move_en_d;
    logic respawn_q, respawn_d;
    logic hit_sel_q, hit_sel_d;
    logic invuln_q, invuln_d;
    logic game_over_q, game_over_d;
    logic sprite_visible_q, sprite_visible_d;

`ifdef PLAYER_BLINK_EN
    localparam int unsigned      BLK_W      = clog2_min1(BLINK_TICKS);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_TICKS - 1);

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
`endif

    // State register, timer and lives.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_ALIVE;
            timer_q <= '0;
            lives_q <= LIVES_RST;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lives_q <= lives_d;
        end
    end

    // Next-state logic. Collisions are only acted on in ALIVE.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        lives_d = lives_q;
        case (state_q)
            ST_ALIVE: begin
                if (collision_i) begin
                    state_d = ST_HIT;
                    timer_d = '0;
                    lives_d = (lives_q == '0) ? '0 : lives_q - 1'b1;
                end
            end
            ST_HIT: begin
                if (tick) begin
                    if (timer_q == HIT_LAST) begin
                        state_d = (lives_q == '0) ? ST_GAME_OVER : ST_RESPAWN;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            ST_RESPAWN: begin
                state_d = ST_INVULN;
                timer_d = '0;
            end
            ST_INVULN: begin
                if (tick) begin
                    if (timer_q == INV_LAST) begin
                        state_d = ST_ALIVE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (restart_i) begin
                    state_d = ST_RESPAWN;
                    lives_d = LIVES_RST;
                end
            end
            default: begin
                state_d = ST_ALIVE;
            end
        endcase
    end

    // Output decode from the next state so every flag is registered and
    // aligned with the state it describes.
    always_comb begin
        hit_sel_d   = (state_d == ST_HIT);
        invuln_d    = (state_d == ST_RESPAWN) || (state_d == ST_INVULN);
        game_over_d = (state_d == ST_GAME_OVER);
        respawn_d   = (state_d == ST_RESPAWN);
        // A tick that coincides with a fresh hit does not move the player.
        move_en_d   = tick && (((state_q == ST_ALIVE) && !collision_i)
                               || (state_q == ST_INVULN));
`ifdef PLAYER_BLINK_EN
        blink_cnt_d      = blink_cnt_q;
        sprite_visible_d = (state_d != ST_GAME_OVER);
        if (state_d == ST_INVULN) begin
            if (state_q != ST_INVULN) begin
                blink_cnt_d      = '0;
                sprite_visible_d = 1'b1;
            end else if (tick && (blink_cnt_q == BLINK_LAST)) begin
                blink_cnt_d      = '0;
                sprite_visible_d = !sprite_visible_q;
            end else if (tick) begin
                blink_cnt_d      = blink_cnt_q + 1'b1;
                sprite_visible_d = sprite_visible_q;
            end else begin
                sprite_visible_d = sprite_visible_q;
            end
        end
`else
        sprite_visible_d = (state_d != ST_GAME_OVER);
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            move_en_q        <= 1'b0;
            respawn_q        <= 1'b0;
            hit_sel_q        <= 1'b0;
            invuln_q         <= 1'b0;
            game_over_q      <= 1'b0;
            sprite_visible_q <= 1'b1;
`ifdef PLAYER_BLINK_EN
            blink_cnt_q      <= '0;
`endif
        end else begin
            move_en_q        <= move_en_d;
            respawn_q        <= respawn_d;
            hit_sel_q        <= hit_sel_d;
            invuln_q         <= invuln_d;
            game_over_q      <= game_over_d;
            sprite_visible_q <= sprite_visible_d;
`ifdef PLAYER_BLINK_EN
            blink_cnt_q      <= blink_cnt_d;
`endif
        end
    end

    assign move_en_o        = move_en_q;
    assign respawn_o        = respawn_q;
    assign hit_sel_o        = hit_sel_q;
    assign invuln_o         = invuln_q;
    assign game_over_o      = game_over_q;
    assign sprite_visible_o = sprite_visible_q;
    assign lives_o          = lives_q;

endmodule

// File: tb/tb_player_life_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_life_ctrl
// Directed bench for player_life_ctrl with TICK_DIV=4, HIT_TICKS=2,
// INVULN_TICKS=4, BLINK_TICKS=1, LIVES_INIT=2. Expected sprite blinking
// follows PLAYER_BLINK_EN.
// cyc counts rising edges since the last reset release; the DUT tick is
// high in the cycle following edge cyc when cyc % 4 == 3.
// -----------------------------------------------------------------------------
module tb_player_life_ctrl;

`ifdef PLAYER_BLINK_EN
    localparam int BLINK_ON = 1;
`else
    localparam int BLINK_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       collision;
    logic       restart;
    logic       move_en;
    logic       respawn;
    logic       hit_sel;
    logic       sprite_visible;
    logic       invuln;
    logic [2:0] lives;
    logic       game_over;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    player_life_ctrl #(
        .TICK_DIV     (4),
        .HIT_TICKS    (2),
        .INVULN_TICKS (4),
        .BLINK_TICKS  (1),
        .LIVES_INIT   (2)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .collision_i      (collision),
        .restart_i        (restart),
        .move_en_o        (move_en),
        .respawn_o        (respawn),
        .hit_sel_o        (hit_sel),
        .sprite_visible_o (sprite_visible),
        .invuln_o         (invuln),
        .lives_o          (lives),
        .game_over_o      (game_over)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc%0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_move_en"},   int'(move_en),        0);
        chk({tag, "_respawn"},   int'(respawn),        0);
        chk({tag, "_hit_sel"},   int'(hit_sel),        0);
        chk({tag, "_invuln"},    int'(invuln),         0);
        chk({tag, "_game_over"}, int'(game_over),      0);
        chk({tag, "_visible"},   int'(sprite_visible), 1);
        chk({tag, "_lives"},     int'(lives),          2);
    endtask

    initial begin
        reset     = 1'b1;
        collision = 1'b0;
        restart   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset = 1'b0;
        cyc   = 0;

        // Idle: move_en every 4th cycle.
        for (int k = 1; k <= 8; k++) begin
            goto(k);
            chk("idle_move_en", int'(move_en), int'((k % 4) == 0));
        end
        chk("idle_lives", int'(lives), 2);
        chk("idle_visible", int'(sprite_visible), 1);

        // Collision pulse on a tick cycle: hit wins, move_en suppressed.
        goto(11);
        collision = 1'b1;
        goto(12);
        collision = 1'b0;
        chk("hit_lives", int'(lives), 1);
        chk("hit_sel", int'(hit_sel), 1);
        chk("hit_move_sup", int'(move_en), 0);
        chk("hit_invuln", int'(invuln), 0);
        goto(16);
        chk("hit_frozen", int'(move_en), 0);
        chk("hit_sel_mid", int'(hit_sel), 1);
        goto(19);
        chk("hit_sel_last", int'(hit_sel), 1);
        chk("hit_no_respawn", int'(respawn), 0);
        goto(20);
        chk("respawn_pulse", int'(respawn), 1);
        chk("respawn_invuln", int'(invuln), 1);
        chk("respawn_hit_sel", int'(hit_sel), 0);
        chk("respawn_lives", int'(lives), 1);
        goto(21);
        chk("respawn_end", int'(respawn), 0);
        chk("inv_invuln", int'(invuln), 1);
        chk("inv_vis_entry", int'(sprite_visible), 1);
        goto(24);
        chk("inv_move_en", int'(move_en), 1);
        chk("inv_blink1", int'(sprite_visible), 1 - BLINK_ON);
        goto(28);
        chk("inv_blink2", int'(sprite_visible), 1);
        goto(35);
        chk("inv_last", int'(invuln), 1);
        goto(36);
        chk("alive_invuln", int'(invuln), 0);
        chk("alive_move_en", int'(move_en), 1);
        chk("alive_visible", int'(sprite_visible), 1);

        // Second hit leads to GAME_OVER.
        collision = 1'b1;
        goto(37);
        collision = 1'b0;
        chk("hit2_lives", int'(lives), 0);
        chk("hit2_sel", int'(hit_sel), 1);
        goto(43);
        chk("hit2_sel_last", int'(hit_sel), 1);
        chk("hit2_no_go", int'(game_over), 0);
        goto(44);
        chk("go_flag", int'(game_over), 1);
        chk("go_visible", int'(sprite_visible), 0);
        chk("go_hit_sel", int'(hit_sel), 0);
        chk("go_lives", int'(lives), 0);
        chk("go_move_en", int'(move_en), 0);
        collision = 1'b1;
        goto(45);
        chk("go_coll_flag", int'(game_over), 1);
        chk("go_coll_lives", int'(lives), 0);
        chk("go_coll_respawn", int'(respawn), 0);

        // restart together with collision: restart wins.
        restart = 1'b1;
        goto(46);
        restart   = 1'b0;
        collision = 1'b0;
        chk("rs_respawn", int'(respawn), 1);
        chk("rs_lives", int'(lives), 2);
        chk("rs_go", int'(game_over), 0);
        chk("rs_invuln", int'(invuln), 1);
        chk("rs_visible", int'(sprite_visible), 1);
        goto(47);
        chk("rs_respawn_end", int'(respawn), 0);
        goto(48);
        chk("rs_inv_move_en", int'(move_en), 1);
        chk("rs_inv_blink", int'(sprite_visible), 1 - BLINK_ON);
        goto(49);
        chk("rs_inv_invuln", int'(invuln), 1);

        // Asynchronous reset mid-INVULN.
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;

        // restart outside GAME_OVER is ignored.
        restart = 1'b1;
        goto(1);
        restart = 1'b0;
        chk("alive_rs_respawn", int'(respawn), 0);
        chk("alive_rs_lives", int'(lives), 2);
        chk("alive_rs_invuln", int'(invuln), 0);

        // Collision held high: one decrement until ALIVE is re-entered.
        collision = 1'b1;
        goto(2);
        chk("hold_lives1", int'(lives), 1);
        chk("hold_hit_sel", int'(hit_sel), 1);
        goto(8);
        chk("hold_respawn", int'(respawn), 1);
        chk("hold_lives_rsp", int'(lives), 1);
        goto(23);
        chk("hold_inv_invuln", int'(invuln), 1);
        chk("hold_inv_lives", int'(lives), 1);
        goto(24);
        chk("hold_alive_invuln", int'(invuln), 0);
        chk("hold_alive_lives", int'(lives), 1);
        chk("hold_alive_move", int'(move_en), 1);
        goto(25);
        chk("hold_rehit_lives", int'(lives), 0);
        chk("hold_rehit_sel", int'(hit_sel), 1);
        collision = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
